// File: rtl/esn_seq_ctrl.sv
// esn_seq_ctrl: ESN washout/train/test sequencer; optional WAIT timeout via ESN_CTRL_TIMEOUT_EN
module esn_seq_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int N_SAMPLES = 64,
  parameter int WASHOUT   = 8,
  parameter int N_EPOCHS  = 4,
  parameter int EPOCH_W   = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst_N,
  input  logic               start,
  input  logic               abort,
  input  logic               res_ack,
  output logic               res_step,
  output logic [ADDR_W-1:0]  addr,
  output logic               rd_ce,
  output logic               rd_learn,
  output logic [1:0]         phase,
  output logic [EPOCH_W-1:0] epoch,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam logic [1:0] P_IDLE = 2'd0, P_WASH = 2'd1, P_TRAIN = 2'd2, P_TEST = 2'd3;
  localparam logic [1:0] S_STEP = 2'd0, S_WAIT = 2'd1, S_COMMIT = 2'd2;
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(N_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] A_WASH = ADDR_W'(WASHOUT);
  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(WASHOUT - 1);
  localparam logic [EPOCH_W-1:0] E_LAST = EPOCH_W'(N_EPOCHS - 1);
  logic [1:0] rs_q, rs_d;
  logic rst_s_n;
  logic [1:0] phase_q, phase_d, sub_q, sub_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic last;
`ifdef ESN_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
`endif
  // reset synchronizer: asserts asynchronously, releases on the second clock edge
  always_comb rs_d = {rs_q[0], 1'b1};
  always_ff @(posedge clk or negedge rst_N)
    if (!rst_N) rs_q <= '0;
    else rs_q <= rs_d;
  assign rst_s_n = rs_q[1];
  assign last = addr_q == A_LAST;
  // next-state: abort first, then IDLE start, then per-sample STEP/WAIT/COMMIT walk
  always_comb begin
    phase_d = phase_q;
    sub_d   = sub_q;
    addr_d  = addr_q;
    epoch_d = epoch_q;
`ifdef ESN_CTRL_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    if (abort) begin
      phase_d = P_IDLE;
      sub_d   = S_STEP;
      addr_d  = '0;
      epoch_d = '0;
    end else if (phase_q == P_IDLE) begin
      if (start) phase_d = (WASHOUT == 0) ? P_TRAIN : P_WASH;
    end else if (sub_q == S_STEP) begin
      sub_d = S_WAIT;
`ifdef ESN_CTRL_TIMEOUT_EN
      cnt_d = '0;
`endif
    end else if (sub_q == S_WAIT) begin
      if (res_ack) sub_d = S_COMMIT;
`ifdef ESN_CTRL_TIMEOUT_EN
      else if (cnt_q == T_LAST) begin
        phase_d = P_IDLE;
        sub_d   = S_STEP;
        addr_d  = '0;
        epoch_d = '0;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
`endif
    end else begin
      sub_d  = S_STEP;
      addr_d = last ? A_WASH : addr_q + 1'b1;
      if (phase_q == P_WASH && addr_q == W_LAST) phase_d = P_TRAIN;
      else if (phase_q == P_TRAIN && last) begin
        if (epoch_q == E_LAST) phase_d = P_TEST;
        else epoch_d = epoch_q + 1'b1;
      end else if (phase_q == P_TEST && last) begin
        phase_d = P_IDLE;
        addr_d  = '0;
        epoch_d = '0;
      end
    end
  end
  // state registers
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) begin
      phase_q <= P_IDLE;
      sub_q   <= S_STEP;
      addr_q  <= '0;
      epoch_q <= '0;
    end else begin
      phase_q <= phase_d;
      sub_q   <= sub_d;
      addr_q  <= addr_d;
      epoch_q <= epoch_d;
    end
`ifdef ESN_CTRL_TIMEOUT_EN
  // WAIT watchdog and sticky error flag
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign busy     = phase_q != P_IDLE;
  assign res_step = busy && sub_q == S_STEP;
  assign rd_ce    = sub_q == S_COMMIT && (phase_q == P_TRAIN || phase_q == P_TEST);
  assign rd_learn = sub_q == S_COMMIT && phase_q == P_TRAIN;
  assign done     = sub_q == S_COMMIT && phase_q == P_TEST && last && !abort;
  assign addr     = addr_q;
  assign phase    = phase_q;
  assign epoch    = epoch_q;
endmodule
